// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetch buffer between the core instruction Wishbone port and memory.
// Define PREFETCH_STATS_EN to build the saturating hit/miss counters; otherwise both read as 0.
module inst_prefetch_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_cyc,
  input  logic                    s_stb,
  input  logic                    s_we,
  input  logic [ADDR_WIDTH-1:0]   s_adr,
  output logic [DATA_WIDTH-1:0]   s_datrd,
  output logic                    s_ack,
  output logic                    m_cyc,
  output logic                    m_stb,
  output logic                    m_we,
  output logic [DATA_WIDTH/8-1:0] m_sel,
  output logic [ADDR_WIDTH-1:0]   m_adr,
  input  logic [DATA_WIDTH-1:0]   m_datrd,
  input  logic                    m_ack,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;
  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] fifo_adr [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_dat [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count, count_next;
  logic [ADDR_WIDTH-1:0] req_adr, fetch_adr, fetch_adr_next;
  logic [DATA_WIDTH-1:0] byp_dat;
  logic pending, waiting, active, byp_ack;
  logic accept, classify, head_hit, hit, miss, in_flight_match;
  logic take_word, bypass, push, pop, flush;
  logic unused_ok;

  assign unused_ok = s_we;

  // A request is classified exactly once, the cycle after it is accepted.
  assign accept          = s_cyc && s_stb && !pending;
  assign classify        = pending && !waiting && !byp_ack;
  assign head_hit        = (count != '0) && (fifo_adr[rd_ptr] == req_adr);
  assign hit             = classify && head_hit;
  assign miss            = classify && !head_hit;
  assign in_flight_match = (state == FETCH) && (fetch_adr == req_adr);
  assign take_word       = (state == FETCH) && m_ack;
  assign bypass          = take_word && in_flight_match && (waiting || miss);
  assign push            = take_word && !bypass && !miss;
  assign pop             = hit;
  assign flush           = miss;

  assign s_ack   = hit || byp_ack;
  assign s_datrd = hit ? fifo_dat[rd_ptr] : byp_dat;
  assign m_cyc   = (state != IDLE);
  assign m_stb   = (state != IDLE);
  assign m_we    = 1'b0;
  assign m_sel   = '1;
  assign m_adr   = fetch_adr;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
  end

  // In DISCARD fetch_adr keeps the abandoned address on the bus; the restart target is req_adr.
  always_comb begin
    state_next     = state;
    fetch_adr_next = fetch_adr;
    case (state)
      IDLE: begin
        if (miss) fetch_adr_next = req_adr;
        if ((active || miss) && (count_next != FULL)) state_next = FETCH;
      end
      FETCH: begin
        if (m_ack) begin
          if (miss && !in_flight_match) fetch_adr_next = req_adr;
          else                          fetch_adr_next = fetch_adr + STEP;
          state_next = (count_next == FULL) ? IDLE : FETCH;
        end else if (miss && !in_flight_match) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (m_ack) begin
          fetch_adr_next = req_adr;
          state_next     = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_adr <= '0;
      req_adr   <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      pending   <= 1'b0;
      waiting   <= 1'b0;
      active    <= 1'b0;
      byp_ack   <= 1'b0;
      byp_dat   <= '0;
    end else begin
      state     <= state_next;
      fetch_adr <= fetch_adr_next;
      count     <= count_next;
      byp_ack   <= bypass;
      if (bypass) byp_dat <= m_datrd;
      if (accept) begin
        req_adr <= {s_adr[ADDR_WIDTH-1:2], 2'b00};
        pending <= 1'b1;
      end else if (s_ack) begin
        pending <= 1'b0;
      end
      if (bypass)    waiting <= 1'b0;
      else if (miss) waiting <= 1'b1;
      if (miss) active <= 1'b1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_adr[wr_ptr] <= fetch_adr;
      fifo_dat[wr_ptr] <= m_datrd;
    end
  end

`ifdef PREFETCH_STATS_EN
  // A miss whose word is already in flight on an empty FIFO is scored as a hit.
  logic        arrive_hit;
  logic [31:0] hit_q, miss_q;

  assign arrive_hit = miss && (count == '0) && in_flight_match;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if ((hit || arrive_hit) && (hit_q != '1)) hit_q <= hit_q + 32'd1;
      if (miss && !arrive_hit && (miss_q != '1)) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Scoreboard bench for inst_prefetch_buffer with a latency-programmable Wishbone memory model.
// Counter expectations follow PREFETCH_STATS_EN.
module tb_inst_prefetch_buffer;
`ifdef PREFETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_datrd;
  logic        s_ack, m_cyc, m_stb, m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_datrd;
  logic        m_ack;
  logic [31:0] hit_count, miss_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ack_total = 0;
  int last_ack_cyc = 0;
  int last_mack_cyc = 0;
  int issue_cyc = 0;
  int mem_lat = 2;
  int wcnt = 0;
  bit mem_hold = 1'b0;
  bit inject_ack = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_log[$];
  logic [31:0] exp_hits = 0;
  logic [31:0] exp_misses = 0;

  inst_prefetch_buffer dut (
    .clk(clk), .rst(rst),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_datrd(s_datrd), .s_ack(s_ack),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr),
    .m_datrd(m_datrd), .m_ack(m_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < mem_log.size()) return mem_log[i];
    return 'x;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: acks each strobe after mem_lat strobed cycles, one cycle wide.
  initial begin
    m_ack = 1'b0;
    m_datrd = '0;
    forever begin
      @(negedge clk);
      if (inject_ack) begin
        m_ack = 1'b1;
        m_datrd = 32'hBAD0_BAD0;
        inject_ack = 1'b0;
        wcnt = 0;
      end else if (m_ack) begin
        m_ack = 1'b0;
        wcnt = 0;
      end else if (m_cyc && m_stb && !mem_hold) begin
        wcnt++;
        if (wcnt >= mem_lat) begin
          m_ack = 1'b1;
          m_datrd = mem_word(m_adr);
          mem_log.push_back(m_adr);
          last_mack_cyc = cyc;
          wcnt = 0;
        end
      end else if (!(m_cyc && m_stb)) begin
        wcnt = 0;
      end
    end
  end

  // Scoreboard: every core ack must match the oldest outstanding expected word.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (s_ack === 1'b1) begin
        ack_total++;
        last_ack_cyc = cyc;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_ack: s_ack=1 s_datrd=%h, required no ack", s_datrd);
        end else begin
          e = exp_q.pop_front();
          if (s_datrd !== e) begin
            miscompares++;
            $display("[TB] FAIL ack_data: got %h, required %h", s_datrd, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] adr, input int hold);
    exp_q.push_back(mem_word(adr));
    s_cyc = 1'b1;
    s_stb = 1'b1;
    s_adr = adr;
    issue_cyc = cyc;
    repeat (hold) tick();
    s_cyc = 1'b0;
    s_stb = 1'b0;
  endtask

  task automatic wait_acks(input int target);
    int n = 0;
    while (ack_total < target && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_quiet();
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 300) begin
      tick();
      n++;
      quiet = m_stb ? 0 : quiet + 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0; s_adr = '0;
    repeat (2) tick();
    vectors++;
    if ({s_ack, m_cyc, m_stb, m_we} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: {s_ack,m_cyc,m_stb,m_we}=%b, required 0000", {s_ack, m_cyc, m_stb, m_we});
    end
    vectors++;
    if (s_datrd !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_datrd: got %h, required 0", s_datrd); end
    vectors++;
    if (m_adr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_madr: got %h, required 0", m_adr); end
    vectors++;
    if (m_sel !== 4'hF) begin miscompares++; $display("[TB] FAIL reset_msel: got %h, required f", m_sel); end
    vectors++;
    if ({hit_count, miss_count} !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_counters: hit=%0d miss=%0d, required 0 0", hit_count, miss_count);
    end
    rst = 1'b1;
    repeat (3) tick();
    vectors++;
    if (m_stb !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_after_reset: m_stb=%b, required 0", m_stb); end
  endtask

  task automatic test_first_miss();
    int a0 = ack_total;
    int base = mem_log.size();
    issue(32'h100, 1);
    exp_misses++;
    wait_acks(a0 + 1);
    vectors++;
    if (ack_total !== a0 + 1) begin miscompares++; $display("[TB] FAIL miss_ack: acks %0d, required %0d", ack_total - a0, 1); end
    vectors++;
    if (log_at(base) !== 32'h100) begin miscompares++; $display("[TB] FAIL miss_first_madr: got %h, required 100", log_at(base)); end
    vectors++;
    if (last_ack_cyc - last_mack_cyc !== 1) begin
      miscompares++;
      $display("[TB] FAIL miss_latency: s_ack %0d cycles after m_ack, required 1", last_ack_cyc - last_mack_cyc);
    end
    wait_quiet();
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (log_at(base + i) !== 32'h100 + 32'(4 * i)) begin
        miscompares++;
        $display("[TB] FAIL fill_adr%0d: got %h, required %h", i, log_at(base + i), 32'h100 + 32'(4 * i));
      end
    end
    vectors++;
    if (mem_log.size() !== base + 5 || m_stb !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fill_stop: fetches %0d m_stb=%b, required 5 and 0", mem_log.size() - base, m_stb);
    end
  endtask

  task automatic test_sequential();
    int base = mem_log.size();
    logic [31:0] seq_adr [2];
    seq_adr[0] = 32'h104;
    seq_adr[1] = 32'h108;
    for (int i = 0; i < 2; i++) begin
      int a0 = ack_total;
      issue(seq_adr[i], 1);
      exp_hits++;
      wait_acks(a0 + 1);
      vectors++;
      if (ack_total !== a0 + 1 || last_ack_cyc - issue_cyc !== 1) begin
        miscompares++;
        $display("[TB] FAIL hit_latency_%h: acks %0d latency %0d, required 1 and 1", seq_adr[i], ack_total - a0, last_ack_cyc - issue_cyc);
      end
      tick();
    end
    wait_quiet();
    vectors++;
    if (log_at(base) !== 32'h114 || log_at(base + 1) !== 32'h118 || mem_log.size() !== base + 2) begin
      miscompares++;
      $display("[TB] FAIL refill: got %h %h (%0d fetches), required 114 118 (2)", log_at(base), log_at(base + 1), mem_log.size() - base);
    end
    vectors++;
    if (hit_count !== (STATS ? exp_hits : 32'd0) || miss_count !== (STATS ? exp_misses : 32'd0)) begin
      miscompares++;
      $display("[TB] FAIL counters_seq: hit=%0d miss=%0d, required %0d %0d", hit_count, miss_count,
               STATS ? exp_hits : 32'd0, STATS ? exp_misses : 32'd0);
    end
  endtask

  task automatic test_jump();
    int a0 = ack_total;
    int base;
    mem_hold = 1'b1;
    issue(32'h10C, 1);
    exp_hits++;
    wait_acks(a0 + 1);
    repeat (3) tick();
    base = mem_log.size();
    issue(32'h200, 1);
    exp_misses++;
    repeat (3) tick();
    vectors++;
    if (m_stb !== 1'b1 || m_adr !== 32'h11C) begin
      miscompares++;
      $display("[TB] FAIL discard_hold: m_stb=%b m_adr=%h, required 1 11c", m_stb, m_adr);
    end
    mem_hold = 1'b0;
    wait_acks(a0 + 2);
    vectors++;
    if (ack_total !== a0 + 2) begin miscompares++; $display("[TB] FAIL jump_ack: acks %0d, required 2", ack_total - a0); end
    vectors++;
    if (log_at(base) !== 32'h11C || log_at(base + 1) !== 32'h200) begin
      miscompares++;
      $display("[TB] FAIL jump_madr: got %h %h, required 11c 200", log_at(base), log_at(base + 1));
    end
    vectors++;
    if (last_ack_cyc - last_mack_cyc !== 1) begin
      miscompares++;
      $display("[TB] FAIL jump_latency: got %0d, required 1", last_ack_cyc - last_mack_cyc);
    end
    vectors++;
    if (hit_count !== (STATS ? exp_hits : 32'd0) || miss_count !== (STATS ? exp_misses : 32'd0)) begin
      miscompares++;
      $display("[TB] FAIL counters_jump: hit=%0d miss=%0d, required %0d %0d", hit_count, miss_count,
               STATS ? exp_hits : 32'd0, STATS ? exp_misses : 32'd0);
    end
  endtask

  task automatic test_wrap();
    int a0;
    int base;
    wait_quiet();
    a0 = ack_total;
    base = mem_log.size();
    issue(32'hFFFF_FFFC, 1);
    exp_misses++;
    wait_acks(a0 + 1);
    wait_quiet();
    vectors++;
    if (log_at(base) !== 32'hFFFF_FFFC || log_at(base + 1) !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL wrap_madr: got %h %h, required fffffffc 00000000", log_at(base), log_at(base + 1));
    end
    issue(32'h0, 1);
    exp_hits++;
    wait_acks(a0 + 2);
    vectors++;
    if (ack_total !== a0 + 2 || last_ack_cyc - issue_cyc !== 1) begin
      miscompares++;
      $display("[TB] FAIL wrap_hit: acks %0d latency %0d, required 2 and 1", ack_total - a0, last_ack_cyc - issue_cyc);
    end
  endtask

  task automatic test_mid_reset();
    int a0;
    wait_quiet();
    mem_hold = 1'b1;
    issue(32'h300, 1);
    repeat (4) tick();
    vectors++;
    if (m_stb !== 1'b1 || m_adr !== 32'h300) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_fetch: m_stb=%b m_adr=%h, required 1 300", m_stb, m_adr);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({m_cyc, m_stb, s_ack} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL async_reset: {m_cyc,m_stb,s_ack}=%b, required 000", {m_cyc, m_stb, s_ack});
    end
    exp_q.delete();
    exp_hits = 0;
    exp_misses = 0;
    a0 = ack_total;
    repeat (2) tick();
    rst = 1'b1;
    mem_hold = 1'b0;
    inject_ack = 1'b1;
    repeat (6) tick();
    vectors++;
    if (ack_total !== a0 || m_stb !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL late_ack: acks %0d m_stb=%b, required 0 and 0", ack_total - a0, m_stb);
    end
    vectors++;
    if ({hit_count, miss_count} !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL counters_cleared: hit=%0d miss=%0d, required 0 0", hit_count, miss_count);
    end
  endtask

  task automatic test_held_stb();
    int a0 = ack_total;
    int base = mem_log.size();
    s_we = 1'b1;
    issue(32'h104, 3);
    s_we = 1'b0;
    exp_misses++;
    wait_acks(a0 + 1);
    repeat (8) tick();
    vectors++;
    if (ack_total !== a0 + 1) begin miscompares++; $display("[TB] FAIL held_stb_acks: got %0d, required 1", ack_total - a0); end
    vectors++;
    if (log_at(base) !== 32'h104) begin miscompares++; $display("[TB] FAIL empty_after_reset: first fetch %h, required 104", log_at(base)); end
    vectors++;
    if (hit_count !== 32'd0 || miss_count !== (STATS ? exp_misses : 32'd0)) begin
      miscompares++;
      $display("[TB] FAIL counters_held: hit=%0d miss=%0d, required 0 %0d", hit_count, miss_count, STATS ? exp_misses : 32'd0);
    end
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_sequential();
    test_jump();
    test_wrap();
    test_mid_reset();
    test_held_stb();
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL outstanding: %0d expected acks never arrived, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
